// File: rtl/violation_handler_if.sv
// ---------------------------------------------------------------------------
// violation_handler_if
//   CPU register-access bus of the violation handler.
//   bus_sel_i   : access request (master -> slave)
//   bus_we_i    : 1 = write, 0 = read
//   bus_addr_i  : register index
//   bus_wdata_i : write data
//   bus_rdata_o : read data, valid only together with bus_ack_o
//   bus_ack_o   : single-cycle access acknowledge (slave -> master)
// ---------------------------------------------------------------------------
interface violation_handler_if;
  logic        bus_sel_i;
  logic        bus_we_i;
  logic [1:0]  bus_addr_i;
  logic [31:0] bus_wdata_i;
  logic [31:0] bus_rdata_o;
  logic        bus_ack_o;

  modport master (
    output bus_sel_i, bus_we_i, bus_addr_i, bus_wdata_i,
    input  bus_rdata_o, bus_ack_o
  );

  modport slave (
    input  bus_sel_i, bus_we_i, bus_addr_i, bus_wdata_i,
    output bus_rdata_o, bus_ack_o
  );
endinterface

// File: rtl/violation_handler.sv
// ---------------------------------------------------------------------------
// violation_handler
//   Logs shadow-stack violations ({PC, monitor FSM state}) into a small FIFO,
//   raises an interrupt while entries are pending and can stall the CPU until
//   software releases it. Software inspects and drains the log over a simple
//   register bus.
//
//   clk               : sole clock, rising edge
//   reset             : asynchronous, active-high reset
//   stack_violation_i : violation flag from the shadow-stack monitor
//   address_i         : PC accompanying the instruction stream
//   fsm_state_i       : monitor FSM state
//   bus               : register-access bus (slave side)
//   irq_o             : interrupt, irq_en AND log not empty (registered)
//   halt_o            : CPU stall request, high while HALTED (registered)
//
//   Register map:
//     0 STATUS     RO : [4:0] count, [5] ovf, [6] halted
//     1 CTRL       RW : [0] irq_en, [1] halt_en
//     2 HEAD_ADDR  RO : address of the oldest entry (0 when empty)
//     3 HEAD_STATE RO : fsm_state of the oldest entry (0 when empty)
//     3 CMD        WO : [0] pop, [1] clear ovf, [2] release halt
// ---------------------------------------------------------------------------
module violation_handler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stack_violation_i,
  input  logic [31:0]         address_i,
  input  logic [4:0]          fsm_state_i,
  violation_handler_if.slave  bus,
  output logic                irq_o,
  output logic                halt_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } halt_state_e;

  // State
  logic              sv_prev_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              ovf_r;
  logic              irq_en_r;
  logic              halt_en_r;
  halt_state_e       state_r;
  logic              halt_r;
  logic              irq_r;
  logic              ack_r;
  logic [31:0]       rdata_r;
  logic [31:0]       addr_mem_r [FIFO_DEPTH];
  logic [4:0]        fsm_mem_r  [FIFO_DEPTH];

  // Decoded per-edge controls
  logic              event_s;
  logic              accept_s;
  logic              wr_s;
  logic              cmd_wr_s;
  logic              ctrl_wr_s;
  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              overflow_s;
  logic              clear_ovf_s;
  logic              release_s;
  logic [31:0]       head_addr_s;
  logic [4:0]        head_state_s;
  logic [31:0]       read_data_s;
  logic              unused_wdata_s;

  assign unused_wdata_s = ^bus.bus_wdata_i[31:3];

  // Event detection, bus decode and FIFO push/pop arbitration
  always_comb begin
    event_s   = stack_violation_i & ~sv_prev_r;
    // While ack is high the held request belongs to the access just served.
    accept_s  = bus.bus_sel_i & ~ack_r;
    wr_s      = accept_s & bus.bus_we_i;
    cmd_wr_s  = wr_s & (bus.bus_addr_i == 2'd3);
    ctrl_wr_s = wr_s & (bus.bus_addr_i == 2'd1);
    empty_s   = (count_r == {CW{1'b0}});
    full_s    = (count_r == FULL_CNT);
    // A pop on an empty log is ignored, even when a push arrives alongside.
    pop_s       = cmd_wr_s & bus.bus_wdata_i[0] & ~empty_s;
    // A pop on the same edge frees the slot the push needs.
    push_s      = event_s & (~full_s | pop_s);
    overflow_s  = event_s & full_s & ~pop_s;
    clear_ovf_s = cmd_wr_s & bus.bus_wdata_i[1];
    release_s   = cmd_wr_s & bus.bus_wdata_i[2];
  end

  // Head-of-log view, zero while empty
  always_comb begin
    if (empty_s) begin
      head_addr_s  = 32'd0;
      head_state_s = 5'd0;
    end else begin
      head_addr_s  = addr_mem_r[rd_ptr_r];
      head_state_s = fsm_mem_r[rd_ptr_r];
    end
  end

  // Register read multiplexer
  always_comb begin
    read_data_s = 32'd0;
    case (bus.bus_addr_i)
      2'd0:    read_data_s = {25'd0, halt_r, ovf_r, 5'(count_r)};
      2'd1:    read_data_s = {30'd0, halt_en_r, irq_en_r};
      2'd2:    read_data_s = head_addr_s;
      2'd3:    read_data_s = {27'd0, head_state_s};
      default: read_data_s = 32'd0;
    endcase
  end

  // Rising-edge detector history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sv_prev_r <= 1'b0;
    end else begin
      sv_prev_r <= stack_violation_i;
    end
  end

  // Log storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= address_i;
      fsm_mem_r[wr_ptr_r]  <= fsm_state_i;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // Setting wins over a coincident clear so no overflow is lost.
      if (overflow_s) begin
        ovf_r <= 1'b1;
      end else if (clear_ovf_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Control register and interrupt output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_r  <= 1'b0;
      halt_en_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        irq_en_r  <= bus.bus_wdata_i[0];
        halt_en_r <= bus.bus_wdata_i[1];
      end
      irq_r <= irq_en_r & ~empty_s;
    end
  end

  // Halt FSM with registered stall output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
      halt_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (event_s && halt_en_r) begin
            state_r <= ST_HALTED;
            halt_r  <= 1'b1;
          end
        end
        ST_HALTED: begin
          // A fresh violation on the release edge keeps the CPU stalled.
          if (release_s && !event_s) begin
            state_r <= ST_RUN;
            halt_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_RUN;
          halt_r  <= 1'b0;
        end
      endcase
    end
  end

  // Bus acknowledge and read data, one cycle after acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ack_r <= accept_s;
      if (accept_s && !bus.bus_we_i) begin
        rdata_r <= read_data_s;
      end else begin
        rdata_r <= 32'd0;
      end
    end
  end

  assign bus.bus_ack_o   = ack_r;
  assign bus.bus_rdata_o = rdata_r;
  assign irq_o           = irq_r;
  assign halt_o          = halt_r;

endmodule

// File: tb/tb_violation_handler.sv
// Self-checking bench for violation_handler with a queue-based reference model.
module tb_violation_handler;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        sv;
  logic [31:0] addr;
  logic [4:0]  fst;
  logic        irq_o;
  logic        halt_o;

  violation_handler_if bus_if();

  violation_handler #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .stack_violation_i (sv),
    .address_i         (addr),
    .fsm_state_i       (fst),
    .bus               (bus_if.slave),
    .irq_o             (irq_o),
    .halt_o            (halt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [36:0] m_q[$];
  bit          m_ovf, m_irq_en, m_halt_en, m_halted, m_prev, m_ack, m_irq;
  logic [31:0] m_rd;

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0: return {25'd0, m_halted, m_ovf, 5'(m_q.size())};
      2'd1: return {30'd0, m_halt_en, m_irq_en};
      2'd2: return (m_q.size() != 0) ? m_q[0][36:5] : 32'd0;
      2'd3: return (m_q.size() != 0) ? {27'd0, m_q[0][4:0]} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_irq_en = 0; m_halt_en = 0; m_halted = 0;
    m_prev = 0; m_ack = 0; m_irq = 0; m_rd = 32'd0;
  endtask

  // One clock edge of the specified behaviour, from the inputs as they stand.
  task automatic model_step();
    bit det, acc, wr, cmd, pop;
    logic [31:0] wd;
    if (reset) begin
      model_reset();
      return;
    end
    det    = sv && !m_prev;
    m_prev = sv;
    acc    = bus_if.bus_sel_i && !m_ack;
    m_ack  = acc;
    wr     = acc && bus_if.bus_we_i;
    cmd    = wr && (bus_if.bus_addr_i == 2'd3);
    wd     = bus_if.bus_wdata_i;
    m_rd   = (acc && !bus_if.bus_we_i) ? m_reg(bus_if.bus_addr_i) : 32'd0;
    m_irq  = m_irq_en && (m_q.size() != 0);
    pop    = cmd && wd[0] && (m_q.size() != 0);
    if (pop) void'(m_q.pop_front());
    if (cmd && wd[1]) m_ovf = 0;
    if (det) begin
      if (m_q.size() < DEPTH) m_q.push_back({addr, fst});
      else m_ovf = 1;
    end
    if (m_halted) begin
      if (cmd && wd[2] && !det) m_halted = 0;
    end else if (det && m_halt_en) begin
      m_halted = 1;
    end
    if (wr && bus_if.bus_addr_i == 2'd1) {m_halt_en, m_irq_en} = wd[1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic bus_access(input logic we, input logic [1:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
    bit ok = 0;
    rd = 32'd0;
    bus_if.bus_sel_i = 1'b1; bus_if.bus_we_i = we;
    bus_if.bus_addr_i = a;   bus_if.bus_wdata_i = d;
    for (int i = 0; i < 4 && !ok; i++) begin
      tick();
      if (bus_if.bus_ack_o === 1'b1) begin
        ok = 1;
        rd = bus_if.bus_rdata_o;
      end
    end
    bus_if.bus_sel_i = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bus_ack_timeout: got no ack, required ack within 4 cycles (addr %0d)", a);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus_access(1'b1, a, d, rd);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] rd);
    bus_access(1'b0, a, 32'd0, rd);
  endtask

  task automatic pulse(input logic [31:0] a, input logic [4:0] s);
    sv = 1'b1; addr = a; fst = s;
    tick();
    sv = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    tick(); tick();
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b required 0", irq_o); end
    n_tests++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b required 0", halt_o); end
    n_tests++; if (bus_if.bus_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b required 0", bus_if.bus_ack_o); end
    n_tests++; if (bus_if.bus_rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", bus_if.bus_rdata_o); end
    reset = 1'b0;
    tick();
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h required 00000000", rd); end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    bus_wr(2'd1, 32'h3);
    sv = 1'b1; addr = 32'h0000_1234; fst = 5'd5;
    tick();
    n_tests++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL basic_halt_on_edge: got %b required 1", halt_o); end
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL basic_irq_early: got %b required 0", irq_o); end
    sv = 1'b0;
    tick();
    n_tests++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %b required 1", irq_o); end
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'h41) begin n_fail++; $display("FAIL basic_status: got %h required 00000041", rd); end
    bus_rd(2'd2, rd);
    n_tests++; if (rd !== 32'h1234) begin n_fail++; $display("FAIL basic_head_addr: got %h required 00001234", rd); end
    bus_rd(2'd3, rd);
    n_tests++; if (rd !== 32'd5) begin n_fail++; $display("FAIL basic_head_state: got %h required 00000005", rd); end
    bus_wr(2'd0, 32'hFFFF_FFFF);  // RO register, must be ignored
    bus_wr(2'd3, 32'h4);
    n_tests++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL basic_release: got %b required 0", halt_o); end
    bus_wr(2'd3, 32'h1);
    bus_wr(2'd1, 32'h0);
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL basic_drained: got %h required 00000000", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    for (int i = 0; i < 5; i++) pulse(32'h1000 + i, 5'(i));
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'h24) begin n_fail++; $display("FAIL ovf_status: got %h required 00000024", rd); end
    for (int i = 0; i < 4; i++) begin
      bus_rd(2'd2, rd);
      n_tests++; if (rd !== 32'h1000 + i) begin n_fail++; $display("FAIL ovf_order_%0d: got %h required %h", i, rd, 32'h1000 + i); end
      bus_wr(2'd3, 32'h1);
    end
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'h20) begin n_fail++; $display("FAIL ovf_sticky: got %h required 00000020", rd); end
    bus_wr(2'd3, 32'h2);
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL ovf_clear: got %h required 00000000", rd); end
  endtask

  task automatic test_held();
    logic [31:0] rd;
    sv = 1'b1; addr = 32'h0ABC; fst = 5'd3;
    for (int i = 0; i < 10; i++) tick();
    sv = 1'b0;
    tick();
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'd1) begin n_fail++; $display("FAIL held_count: got %h required 00000001", rd); end
    bus_wr(2'd3, 32'h1);
  endtask

  task automatic test_full_pop_push();
    logic [31:0] rd;
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h2001; exp_addr[1] = 32'h2002;
    exp_addr[2] = 32'h2003; exp_addr[3] = 32'h2FFF;
    for (int i = 0; i < 4; i++) pulse(32'h2000 + i, 5'(i));
    sv = 1'b1; addr = 32'h2FFF; fst = 5'd7;
    bus_wr(2'd3, 32'h1);
    sv = 1'b0;
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'h04) begin n_fail++; $display("FAIL fullpp_status: got %h required 00000004", rd); end
    for (int i = 0; i < 4; i++) begin
      bus_rd(2'd2, rd);
      n_tests++; if (rd !== exp_addr[i]) begin n_fail++; $display("FAIL fullpp_order_%0d: got %h required %h", i, rd, exp_addr[i]); end
      bus_wr(2'd3, 32'h1);
    end
  endtask

  task automatic test_halt_release();
    logic [31:0] rd;
    bus_wr(2'd1, 32'h2);
    pulse(32'h3000, 5'd1);
    n_tests++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL hr_halted: got %b required 1", halt_o); end
    sv = 1'b1; addr = 32'h3001; fst = 5'd2;
    bus_wr(2'd3, 32'h4);
    sv = 1'b0;
    n_tests++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL hr_coincide: got %b required 1", halt_o); end
    tick();
    bus_wr(2'd3, 32'h4);
    n_tests++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL hr_release: got %b required 0", halt_o); end
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'd2) begin n_fail++; $display("FAIL hr_logged: got %h required 00000002", rd); end
    bus_wr(2'd3, 32'h1);
    bus_wr(2'd3, 32'h1);
    bus_wr(2'd1, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    pulse(32'h4000, 5'd1);
    pulse(32'h4001, 5'd2);
    bus_if.bus_sel_i = 1'b1; bus_if.bus_we_i = 1'b1;
    bus_if.bus_addr_i = 2'd3; bus_if.bus_wdata_i = 32'h1;
    tick();
    n_tests++; if (bus_if.bus_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack: got %b required 1", bus_if.bus_ack_o); end
    tick();  // request still held during the ack cycle
    n_tests++; if (bus_if.bus_ack_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_single: got %b required 0", bus_if.bus_ack_o); end
    bus_if.bus_sel_i = 1'b0;
    tick();
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'd1) begin n_fail++; $display("FAIL b2b_one_pop: got %h required 00000001", rd); end
    bus_rd(2'd2, rd);
    n_tests++; if (rd !== 32'h4001) begin n_fail++; $display("FAIL b2b_head: got %h required 00004001", rd); end
    bus_wr(2'd3, 32'h1);
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    bus_wr(2'd1, 32'h3);
    pulse(32'h5000, 5'd1);
    pulse(32'h5001, 5'd2);
    n_tests++; if (irq_o !== 1'b1 || halt_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got irq=%b halt=%b required 1/1", irq_o, halt_o); end
    bus_if.bus_sel_i = 1'b1; bus_if.bus_we_i = 1'b0; bus_if.bus_addr_i = 2'd0;
    #1 reset = 1'b1;
    model_reset();
    #1;
    n_tests++; if (irq_o !== 1'b0 || halt_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got irq=%b halt=%b required 0/0", irq_o, halt_o); end
    n_tests++; if (bus_if.bus_ack_o !== 1'b0 || bus_if.bus_rdata_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_bus: got ack=%b rdata=%h required 0/0", bus_if.bus_ack_o, bus_if.bus_rdata_o); end
    @(negedge clk);
    tick();
    n_tests++; if (bus_if.bus_ack_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_noack: got %b required 0", bus_if.bus_ack_o); end
    bus_if.bus_sel_i = 1'b0;
    reset = 1'b0;
    tick();
    bus_rd(2'd0, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rstmid_status: got %h required 00000000", rd); end
    bus_rd(2'd1, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rstmid_ctrl: got %h required 00000000", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [1:0]  a;
    int          op;
    for (int i = 0; i < 400; i++) begin
      sv   = ($urandom_range(0, 9) < 3);
      addr = $urandom;
      fst  = 5'($urandom);
      op   = $urandom_range(0, 3);
      a    = 2'($urandom);
      if (op == 2) begin
        bus_rd(a, rd);
        n_tests++; if (rd !== m_rd) begin n_fail++; $display("FAIL rand_read_%0d: reg %0d got %h required %h", i, a, rd, m_rd); end
      end else if (op == 3) begin
        bus_wr(a, (a == 2'd3) ? ($urandom & 32'h7) : $urandom);
      end else begin
        tick();
      end
      n_tests++; if (halt_o !== m_halted) begin n_fail++; $display("FAIL rand_halt_%0d: got %b required %b", i, halt_o, m_halted); end
      n_tests++; if (irq_o !== m_irq) begin n_fail++; $display("FAIL rand_irq_%0d: got %b required %b", i, irq_o, m_irq); end
    end
    sv = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sv = 1'b0; addr = 32'd0; fst = 5'd0;
    bus_if.bus_sel_i = 1'b0; bus_if.bus_we_i = 1'b0;
    bus_if.bus_addr_i = 2'd0; bus_if.bus_wdata_i = 32'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_held();
    test_full_pop_push();
    test_halt_release();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
